// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : fir_pkg
//  Brief   : Shared constants and state encoding for the FIR coefficient
//            load sequencer.
//  Rev     : 1.0  initial release
// ============================================================================
package fir_pkg;

   localparam int NUM_BANKS     = 4;
   localparam int TAPS_PER_BANK = 10;
   localparam int COEFF_W       = 16;
   localparam int TOTAL_TAPS    = NUM_BANKS * TAPS_PER_BANK;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WAIT_SLOT = 3'd1,
      ST_LOAD      = 3'd2,
      ST_BANK_GAP  = 3'd3,
      ST_FLUSH     = 3'd4,
      ST_DONE      = 3'd5
   } state_t;

endpackage
`default_nettype wire

// File: rtl/fir_coeff_sequencer.sv
`default_nettype none
// ============================================================================
//  Module  : fir_coeff_sequencer
//  Brief   : Streams 40 coefficient words bank by bank into the FIR filter's
//            coefficient-update port, aligned to a sample boundary.
//  Rev     : 1.0  initial release
// ============================================================================
module fir_coeff_sequencer
   import fir_pkg::*;
#(
   parameter int TIMEOUT = 1023
) (
   input  logic               iClk12M,
   input  logic               iRst,
   input  logic               iEnSample600k,
   input  logic               iLoadReq,
   input  logic               iCoeffValid,
   input  logic [COEFF_W-1:0] iCoeff,
   output logic               oCoeffReady,
   output logic               oCoeffUpdateFlag,
   output logic               oMemRdFlag,
   output logic [1:0]         oModuleSel,
   output logic [3:0]         oAddr,
   output logic [COEFF_W-1:0] oWtDtRam,
   output logic               oWrStb,
   output logic               oBusy,
   output logic               oDone,
   output logic               oErr
);

   localparam int          IDLE_W    = $clog2(TIMEOUT + 1);
   localparam logic [1:0]  LAST_BANK = 2'(NUM_BANKS - 1);
   localparam logic [3:0]  LAST_TAP  = 4'(TAPS_PER_BANK - 1);
   localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT - 1);

   state_t            r_state;
   logic [1:0]        r_bank;
   logic [3:0]        r_tap;
   logic [IDLE_W-1:0] r_idleCnt;
   logic              w_accept;

   // oCoeffReady is only ever high while in LOAD, so it qualifies the handshake.
   assign w_accept = (r_state == ST_LOAD) && oCoeffReady && iCoeffValid;

   always_ff @(posedge iClk12M) begin
      if (iRst) begin
         r_state          <= ST_IDLE;
         r_bank           <= 2'd0;
         r_tap            <= 4'd0;
         r_idleCnt        <= '0;
         oCoeffReady      <= 1'b0;
         oCoeffUpdateFlag <= 1'b0;
         oMemRdFlag       <= 1'b0;
         oModuleSel       <= 2'd0;
         oAddr            <= 4'd0;
         oWtDtRam         <= '0;
         oWrStb           <= 1'b0;
         oBusy            <= 1'b0;
         oDone            <= 1'b0;
         oErr             <= 1'b0;
      end else begin
         oWrStb <= 1'b0;
         oDone  <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (iLoadReq) begin
                  r_state          <= ST_WAIT_SLOT;
                  oErr             <= 1'b0;
                  oMemRdFlag       <= 1'b0;
                  oCoeffUpdateFlag <= 1'b1;
                  oBusy            <= 1'b1;
               end
            end

            ST_WAIT_SLOT: begin
               r_bank    <= 2'd0;
               r_tap     <= 4'd0;
               r_idleCnt <= '0;
               if (iEnSample600k) begin
                  r_state     <= ST_LOAD;
                  oCoeffReady <= 1'b1;
               end
            end

            ST_LOAD: begin
               if (w_accept) begin
                  oWrStb     <= 1'b1;
                  oModuleSel <= r_bank;
                  oAddr      <= r_tap;
                  oWtDtRam   <= iCoeff;
                  r_idleCnt  <= '0;
                  if (r_tap == LAST_TAP) begin
                     r_tap       <= 4'd0;
                     oCoeffReady <= 1'b0;
                     if (r_bank == LAST_BANK) begin
                        r_state <= ST_FLUSH;
                     end else begin
                        r_bank  <= r_bank + 2'd1;
                        r_state <= ST_BANK_GAP;
                     end
                  end else begin
                     r_tap <= r_tap + 4'd1;
                  end
               end else if (r_idleCnt == IDLE_LIMIT) begin
                  // Source stalled too long: abandon the partial load.
                  r_state          <= ST_IDLE;
                  oErr             <= 1'b1;
                  oCoeffUpdateFlag <= 1'b0;
                  oMemRdFlag       <= 1'b0;
                  oCoeffReady      <= 1'b0;
                  oBusy            <= 1'b0;
               end else begin
                  r_idleCnt <= r_idleCnt + 1'b1;
               end
            end

            ST_BANK_GAP: begin
               r_state     <= ST_LOAD;
               oCoeffReady <= 1'b1;
               r_idleCnt   <= '0;
            end

            ST_FLUSH: begin
               r_state <= ST_DONE;
            end

            ST_DONE: begin
               r_state          <= ST_IDLE;
               oDone            <= 1'b1;
               oCoeffUpdateFlag <= 1'b0;
               oMemRdFlag       <= 1'b1;
               oBusy            <= 1'b0;
            end

            default: begin
               r_state          <= ST_IDLE;
               oCoeffReady      <= 1'b0;
               oCoeffUpdateFlag <= 1'b0;
               oBusy            <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fir_coeff_sequencer.sv
`default_nettype none
// ============================================================================
//  Module  : tb_fir_coeff_sequencer
//  Brief   : Randomized scoreboard bench for fir_coeff_sequencer.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_fir_coeff_sequencer;
   import fir_pkg::*;

   localparam int TIMEOUT = 1023;

   logic               iClk12M = 1'b0;
   logic               iRst;
   logic               iEnSample600k;
   logic               iLoadReq;
   logic               iCoeffValid;
   logic [COEFF_W-1:0] iCoeff;
   logic               oCoeffReady;
   logic               oCoeffUpdateFlag;
   logic               oMemRdFlag;
   logic [1:0]         oModuleSel;
   logic [3:0]         oAddr;
   logic [COEFF_W-1:0] oWtDtRam;
   logic               oWrStb;
   logic               oBusy;
   logic               oDone;
   logic               oErr;

   fir_coeff_sequencer #(.TIMEOUT(TIMEOUT)) dut (
      .iClk12M          (iClk12M),
      .iRst             (iRst),
      .iEnSample600k    (iEnSample600k),
      .iLoadReq         (iLoadReq),
      .iCoeffValid      (iCoeffValid),
      .iCoeff           (iCoeff),
      .oCoeffReady      (oCoeffReady),
      .oCoeffUpdateFlag (oCoeffUpdateFlag),
      .oMemRdFlag       (oMemRdFlag),
      .oModuleSel       (oModuleSel),
      .oAddr            (oAddr),
      .oWtDtRam         (oWtDtRam),
      .oWrStb           (oWrStb),
      .oBusy            (oBusy),
      .oDone            (oDone),
      .oErr             (oErr)
   );

   always #5 iClk12M = ~iClk12M;

   typedef struct packed {
      logic [1:0]         bank;
      logic [3:0]         tap;
      logic [COEFF_W-1:0] data;
   } wr_t;

   wr_t expQ[$];
   int  gapQ[$];
   int  checks   = 0;
   int  errors   = 0;
   int  doneCnt  = 0;
   int  strobeCnt = 0;
   bit  monEn    = 1'b0;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %0d required %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge iClk12M);
      #1;
   endtask

   // Scoreboard monitor: every write strobe must match the oldest expected write.
   always @(negedge iClk12M) begin
      if (monEn) begin
         if (oDone) doneCnt++;
         if (oWrStb) begin
            strobeCnt++;
            checks++;
            if (expQ.size() == 0) begin
               errors++;
               $display("FAIL unexpected_strobe: actual bank %0d tap %0d data %h, required no write",
                        oModuleSel, oAddr, oWtDtRam);
            end else begin
               wr_t e;
               e = expQ.pop_front();
               if (oModuleSel !== e.bank || oAddr !== e.tap || oWtDtRam !== e.data) begin
                  errors++;
                  $display("FAIL write_data: actual bank %0d tap %0d data %h, required bank %0d tap %0d data %h",
                           oModuleSel, oAddr, oWtDtRam, e.bank, e.tap, e.data);
               end
            end
         end
      end
   end

   function automatic logic [28:0] allOutputs();
      return {oCoeffReady, oCoeffUpdateFlag, oMemRdFlag, oModuleSel, oAddr,
              oWtDtRam, oWrStb, oBusy, oDone, oErr};
   endfunction

   // Pulse a load request (optionally with a same-cycle strobe), then strobe.
   task automatic startLoad(input bit strobeWithReq, input int idleCycles, output int viol);
      viol = 0;
      iLoadReq      = 1'b1;
      iEnSample600k = strobeWithReq;
      tick();
      iLoadReq      = 1'b0;
      iEnSample600k = 1'b0;
      repeat (idleCycles) begin
         if (oCoeffReady || oWrStb) viol++;
         tick();
      end
      if (oCoeffReady || oWrStb) viol++;
      iEnSample600k = 1'b1;
      tick();
      iEnSample600k = 1'b0;
      chk("ready_after_strobe", oCoeffReady, 1);
   endtask

   // mode 0: valid always, sequential data; 1: valid 1,0,0 pattern; 2: random valid.
   task automatic feed(input int target, input int mode, input int reqAt, output int cycles);
      int acc;
      int ph;
      logic v;
      wr_t w;
      acc = 0;
      ph = 0;
      cycles = 0;
      gapQ.delete();
      while (acc < target && cycles < 2000) begin
         case (mode)
            0:       v = 1'b1;
            1:       v = (ph % 3 == 0);
            default: v = 1'($urandom_range(0, 1));
         endcase
         ph++;
         iCoeffValid = v;
         iCoeff      = (mode == 0) ? COEFF_W'(acc + 1) : COEFF_W'($urandom);
         iLoadReq    = (acc == reqAt);
         if (v && oCoeffReady) begin
            w.bank = 2'(acc / TAPS_PER_BANK);
            w.tap  = 4'(acc % TAPS_PER_BANK);
            w.data = iCoeff;
            expQ.push_back(w);
            acc++;
         end else if (!oCoeffReady && acc > 0) begin
            gapQ.push_back(acc);
         end
         tick();
         cycles++;
      end
      iCoeffValid = 1'b0;
      iLoadReq    = 1'b0;
      if (cycles >= 2000) chk("feed_budget", acc, target);
   endtask

   task automatic waitDone(output int n);
      n = 0;
      while (!oDone && n < 20) begin
         tick();
         n++;
      end
      chk("done_seen", oDone, 1);
   endtask

   function automatic int gapCode();
      if (gapQ.size() != 3) return -1;
      return gapQ[0] * 10000 + gapQ[1] * 100 + gapQ[2];
   endfunction

   initial begin
      int viol;
      int cyc;
      int n;
      int d0;
      int stall;

      iRst = 1'b1; iEnSample600k = 1'b0; iLoadReq = 1'b0;
      iCoeffValid = 1'b0; iCoeff = '0;
      repeat (3) tick();
      chk("reset_outputs", allOutputs(), 0);
      iRst = 1'b0;
      monEn = 1'b1;
      tick();

      // Full load, sequential words, valid held high.
      startLoad(1'b0, 2, viol);
      chk("update_flag_in_load", oCoeffUpdateFlag, 1);
      chk("busy_in_load", oBusy, 1);
      feed(TOTAL_TAPS, 0, -1, cyc);
      chk("load_cycles", cyc, 43);
      chk("gap_positions", gapCode(), 102030);
      waitDone(n);
      chk("flush_done_latency", n, 2);
      chk("memrd_at_done", oMemRdFlag, 1);
      chk("update_flag_after_done", oCoeffUpdateFlag, 0);
      tick();
      chk("memrd_after_done", oMemRdFlag, 1);
      chk("busy_after_done", oBusy, 0);
      chk("done_count_1", doneCnt, 1);
      chk("strobe_count_1", strobeCnt, TOTAL_TAPS);
      chk("queue_empty_1", expQ.size(), 0);

      // Sample alignment (request and strobe together), then backpressure with a stray request.
      startLoad(1'b1, 50, viol);
      chk("no_ready_before_strobe", viol, 0);
      chk("memrd_dropped", oMemRdFlag, 0);
      d0 = doneCnt;
      feed(TOTAL_TAPS, 1, 15, cyc);
      chk("gap_positions_bp", gapCode(), 102030);
      waitDone(n);
      repeat (5) tick();
      chk("single_done_bp", doneCnt - d0, 1);
      chk("idle_after_bp", oBusy, 0);
      chk("queue_empty_2", expQ.size(), 0);

      // Random valid full load.
      startLoad(1'b0, $urandom_range(0, 5), viol);
      feed(TOTAL_TAPS, 2, -1, cyc);
      waitDone(n);
      chk("memrd_random", oMemRdFlag, 1);

      // Timeout after 17 words.
      startLoad(1'b0, 1, viol);
      feed(17, 2, -1, cyc);
      stall = 0;
      while (oBusy && stall < TIMEOUT + 100) begin
         if (oCoeffReady) stall++;
         tick();
      end
      chk("timeout_stall_cycles", stall, TIMEOUT);
      chk("timeout_err", oErr, 1);
      chk("timeout_memrd", oMemRdFlag, 0);
      chk("timeout_update_flag", oCoeffUpdateFlag, 0);
      chk("timeout_ready", oCoeffReady, 0);
      chk("queue_empty_timeout", expQ.size(), 0);
      tick();
      chk("err_sticky", oErr, 1);

      // New request clears the error; reset at word 25.
      startLoad(1'b0, 0, viol);
      chk("err_cleared", oErr, 0);
      feed(25, 2, -1, cyc);
      iRst = 1'b1;
      tick();
      chk("reset_midload", allOutputs(), 0);
      iRst = 1'b0;
      chk("queue_empty_reset", expQ.size(), 0);
      tick();

      // Fresh load after reset.
      d0 = doneCnt;
      startLoad(1'b0, 3, viol);
      feed(TOTAL_TAPS, 2, -1, cyc);
      waitDone(n);
      tick();
      chk("memrd_after_reset_load", oMemRdFlag, 1);
      chk("done_after_reset_load", doneCnt - d0, 1);
      chk("queue_empty_final", expQ.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fir_coeff_sequencer.md
# fir_coeff_sequencer

Coefficient load sequencer for the reconfigurable 40-tap FIR filter (4 RAM/MAC banks × 10 taps). Accepts a stream of 40 coefficient words over a valid/ready handshake and drives them bank by bank into the filter's coefficient-update interface. Each load is aligned to a sample boundary. The filter's read/run mode is gated until a complete, error-free load has finished. Sits between the host/configuration source and the filter top.

## Interface
- NUM_BANKS, 4, number of RAM/MAC banks (oModuleSel width fixed at 2)
- TAPS_PER_BANK, 10, coefficients per bank (oAddr width fixed at 4)
- COEFF_W, 16, coefficient width
- TIMEOUT, 1023, max idle cycles waiting for iCoeffValid inside a load
- iClk12M  in  1  system clock; one clock domain
- iRst  in  1  synchronous reset, active-high
- iEnSample600k  in  1  sample strobe, one cycle wide
- iLoadReq  in  1  start-load pulse
- iCoeffValid  in  1  coefficient word valid
- iCoeff  in  COEFF_W  coefficient word
- oCoeffReady  out  1  sequencer can accept a word this cycle
- oCoeffUpdateFlag  out  1  filter in coefficient-write mode
- oMemRdFlag  out  1  filter in read/run mode
- oModuleSel  out  2  target bank of the current write
- oAddr  out  4  tap index within the bank
- oWtDtRam  out  COEFF_W  write data
- oWrStb  out  1  one-cycle write strobe qualifying oModuleSel/oAddr/oWtDtRam
- oBusy  out  1  load in progress (any state other than IDLE)
- oDone  out  1  one-cycle pulse on successful completion
- oErr  out  1  sticky timeout error, cleared by the next iLoadReq or reset

## Operation
- States: IDLE, WAIT_SLOT, LOAD, BANK_GAP, FLUSH, DONE.
- IDLE:
  - iLoadReq=1 → WAIT_SLOT.
  - Clear oErr.
  - Drop oMemRdFlag to 0.
- WAIT_SLOT:
  - iEnSample600k=1 → LOAD.
  - Set oCoeffUpdateFlag=1.
  - Clear bank/tap counters.
- LOAD:
  - oCoeffReady=1.
  - Accept when iCoeffValid && oCoeffReady. Next cycle: oWrStb=1, oModuleSel=bank, oAddr=tap, oWtDtRam=word.
  - tap increments on each accept.
  - tap reaches TAPS_PER_BANK−1 on accept, with bank<3: tap←0, bank++, → BANK_GAP.
  - 40th accept (bank 3, tap 9) → FLUSH.
- BANK_GAP: exactly one cycle with oCoeffReady=0, then → LOAD. Gives the filter one cycle to switch banks.
- FLUSH: one cycle; the last write strobe is visible. Then → DONE.
- DONE (one cycle):
  - oDone=1.
  - oCoeffUpdateFlag←0.
  - oMemRdFlag←1.
  - → IDLE.
- Timeout:
  - Idle counter increments on each LOAD cycle without an accept; it resets on accept and on LOAD entry.
  - Reaching TIMEOUT → IDLE with oErr=1, oCoeffUpdateFlag=0, oMemRdFlag=0. The partial load is abandoned.
- iLoadReq outside IDLE is ignored.
- iCoeffValid outside LOAD is ignored; no accept occurs.
- Counter widths: bank 2 bits, tap 4 bits, idle counter $clog2(TIMEOUT+1) bits.

## Timing
- All outputs registered.
- Reset values:
  - state IDLE
  - oCoeffReady 0, oCoeffUpdateFlag 0, oMemRdFlag 0
  - oModuleSel 0, oAddr 0, oWtDtRam 0
  - oWrStb 0, oBusy 0, oDone 0, oErr 0
- Accept-to-strobe latency: 1 cycle.
- Minimum load time from the LOAD-entry cycle: 40 accepts + 3 gaps = 43 cycles, then FLUSH 1 + DONE 1.
- oMemRdFlag rises in the cycle after DONE is entered, together with oDone.
- iLoadReq and iEnSample600k in the same cycle while IDLE: go to WAIT_SLOT only. The load waits for the next strobe.
- Reset mid-load: immediate return to reset values. oMemRdFlag stays 0 until a later complete load.
- Timeout and accept in the same cycle: the accept wins and the counter clears.

## Structure
- Shared package fir_pkg:
  - state enum
  - NUM_BANKS, TAPS_PER_BANK, COEFF_W constants
  - total-tap constant = 40
- Single module; no sub-module. The idle/timeout counter is inline.

## Test plan
- Full load, valid held high:
  - Pulse iLoadReq, then iEnSample600k.
  - Feed words 0x0001..0x0028.
  - Expect 40 oWrStb pulses at (bank,tap) = (0,0)…(3,9) with matching data.
  - Expect ready low for one cycle after taps 9/19/29.
  - Expect oDone one cycle; oMemRdFlag=1 afterwards.
- Sample alignment: iLoadReq with no strobe for 50 cycles → oCoeffReady stays 0 and no oWrStb. Strobe → LOAD next cycle.
- Backpressure: iCoeffValid toggles 1,0,0,1… → strobes only on accepted words; ordering and data unchanged.
- Timeout:
  - Stall after 17 words for TIMEOUT cycles.
  - Expect oErr=1, IDLE, oMemRdFlag=0, oCoeffUpdateFlag=0.
  - Next iLoadReq clears oErr.
- Reset mid-load: assert iRst at word 25 → all outputs at reset values the next cycle. A fresh full load then completes normally.
- iLoadReq pulsed during LOAD → ignored; the counters continue to 40 and complete once.
